// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reorder_buffer_pkg                                                 |
// | Shared widths, id types and id/index helpers for the ROB slice.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int IDX_W    = $clog2(ROB_SIZE);
  localparam int CNT_W    = $clog2(ROB_SIZE + 1);

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [REG_W-1:0]    reg_pos_t;
  typedef logic [IDX_W-1:0]    rob_idx_t;
  typedef logic [CNT_W-1:0]    rob_cnt_t;

  localparam rob_id_t INVALID_ROB = '0;

  typedef struct packed {
    logic  ready;
    data_t value;
  } query_rsp_t;

  // Ids are 1-based so that 0 can mean "no producer".
  function automatic rob_id_t idx_to_id(input rob_idx_t idx);
    return rob_id_t'(idx) + rob_id_t'(1);
  endfunction

  function automatic rob_idx_t id_to_idx(input rob_id_t id);
    return rob_idx_t'(id - rob_id_t'(1));
  endfunction

  function automatic logic id_in_range(input rob_id_t id);
    return (id != INVALID_ROB) && (id <= rob_id_t'(ROB_SIZE));
  endfunction

  function automatic rob_idx_t ptr_inc(input rob_idx_t p);
    return (p == rob_idx_t'(ROB_SIZE - 1)) ? '0 : p + rob_idx_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reorder_buffer_if                                                  |
// | Dispatch, CDB, operand-query and retire signals of the ROB.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     alloc_sign_from_cmd;
  reg_pos_t rd_from_cmd;
  logic     is_store_from_cmd;
  logic     is_branch_from_cmd;
  logic     pred_taken_from_cmd;
  rob_id_t  rob_id_to_cmd;
  logic     full_to_cmd;

  logic     cdb_valid;
  rob_id_t  cdb_rob_id;
  data_t    cdb_value;
  logic     cdb_taken;
  data_t    cdb_target_pc;

  rob_id_t  query1_id;
  logic     query1_ready;
  data_t    query1_value;
  rob_id_t  query2_id;
  logic     query2_ready;
  data_t    query2_value;

  logic     commit_sign_to_reg;
  reg_pos_t rd_to_reg;
  data_t    V_to_reg;
  rob_id_t  Q_to_reg;
  logic     rollback_sign;
  data_t    rollback_pc;
  logic     store_commit_sign;
  rob_id_t  store_commit_rob_id;

  modport slave (
    input  alloc_sign_from_cmd, rd_from_cmd, is_store_from_cmd, is_branch_from_cmd,
           pred_taken_from_cmd, cdb_valid, cdb_rob_id, cdb_value, cdb_taken,
           cdb_target_pc, query1_id, query2_id,
    output rob_id_to_cmd, full_to_cmd, query1_ready, query1_value, query2_ready,
           query2_value, commit_sign_to_reg, rd_to_reg, V_to_reg, Q_to_reg,
           rollback_sign, rollback_pc, store_commit_sign, store_commit_rob_id
  );

  modport master (
    output alloc_sign_from_cmd, rd_from_cmd, is_store_from_cmd, is_branch_from_cmd,
           pred_taken_from_cmd, cdb_valid, cdb_rob_id, cdb_value, cdb_taken,
           cdb_target_pc, query1_id, query2_id,
    input  rob_id_to_cmd, full_to_cmd, query1_ready, query1_value, query2_ready,
           query2_value, commit_sign_to_reg, rd_to_reg, V_to_reg, Q_to_reg,
           rollback_sign, rollback_pc, store_commit_sign, store_commit_rob_id
  );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reorder_buffer                                                     |
// | In-order retirement queue: alloc at tail, CDB fill, retire at head.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reorder_buffer_if.slave  rob
);

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_is_store;
  logic [ROB_SIZE-1:0] r_is_branch;
  logic [ROB_SIZE-1:0] r_pred_taken;
  logic [ROB_SIZE-1:0] r_taken;
  reg_pos_t            r_rd     [ROB_SIZE];
  data_t               r_value  [ROB_SIZE];
  data_t               r_target [ROB_SIZE];

  rob_idx_t r_head;
  rob_idx_t r_tail;
  rob_cnt_t r_count;

  logic     r_commit_sign;
  reg_pos_t r_rd_out;
  data_t    r_v_out;
  rob_id_t  r_q_out;
  logic     r_rollback;
  data_t    r_rollback_pc;
  logic     r_store_commit;
  rob_id_t  r_store_id;

  logic       w_full;
  logic       w_alloc;
  logic       w_cdb_live;
  logic       w_cdb_hit;
  rob_idx_t   w_cdb_idx;
  logic       w_retire;
  logic       w_mispredict;
  logic       w_flush;
  query_rsp_t w_q1;
  query_rsp_t w_q2;

  assign w_full     = (r_count == rob_cnt_t'(ROB_SIZE));
  assign w_alloc    = rob.alloc_sign_from_cmd && !w_full && !r_rollback;
  assign w_cdb_live = rob.cdb_valid && !r_rollback;
  assign w_cdb_idx  = id_to_idx(rob.cdb_rob_id);
  assign w_cdb_hit  = w_cdb_live && id_in_range(rob.cdb_rob_id) && r_busy[w_cdb_idx];

  // Readiness is the registered value, so a CDB write to the head retires one cycle later.
  assign w_retire     = r_busy[r_head] && r_ready[r_head];
  assign w_mispredict = r_is_branch[r_head] && (r_taken[r_head] != r_pred_taken[r_head]);
  assign w_flush      = w_retire && w_mispredict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_ready      <= '0;
      r_is_store   <= '0;
      r_is_branch  <= '0;
      r_pred_taken <= '0;
      r_taken      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else if (w_flush) begin
      r_busy  <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_busy[r_tail]       <= 1'b1;
        r_ready[r_tail]      <= 1'b0;
        r_is_store[r_tail]   <= rob.is_store_from_cmd;
        r_is_branch[r_tail]  <= rob.is_branch_from_cmd;
        r_pred_taken[r_tail] <= rob.pred_taken_from_cmd;
        r_tail               <= ptr_inc(r_tail);
      end
      if (w_cdb_hit) begin
        r_ready[w_cdb_idx] <= 1'b1;
        r_taken[w_cdb_idx] <= rob.cdb_taken;
      end
      if (w_retire) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + rob_cnt_t'(1);
        2'b01:   r_count <= r_count - rob_cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is only read behind busy/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rd[r_tail] <= rob.rd_from_cmd;
    end
    if (w_cdb_hit) begin
      r_value[w_cdb_idx]  <= rob.cdb_value;
      r_target[w_cdb_idx] <= rob.cdb_target_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_sign  <= 1'b0;
      r_rd_out       <= '0;
      r_v_out        <= '0;
      r_q_out        <= '0;
      r_rollback     <= 1'b0;
      r_rollback_pc  <= '0;
      r_store_commit <= 1'b0;
      r_store_id     <= '0;
    end else begin
      r_commit_sign  <= w_retire && !r_is_store[r_head];
      r_store_commit <= w_retire && r_is_store[r_head];
      r_rollback     <= w_flush;
      if (w_retire && !r_is_store[r_head]) begin
        r_rd_out <= r_rd[r_head];
        r_v_out  <= r_value[r_head];
        r_q_out  <= idx_to_id(r_head);
      end
      if (w_retire && r_is_store[r_head]) begin
        r_store_id <= idx_to_id(r_head);
      end
      if (w_flush) begin
        r_rollback_pc <= r_target[r_head];
      end
    end
  end

  function automatic query_rsp_t lookup(input rob_id_t id);
    query_rsp_t rsp;
    rob_idx_t   idx;
    rsp = '0;
    idx = id_to_idx(id);
    if (id_in_range(id) && r_busy[idx]) begin
      if (w_cdb_live && (rob.cdb_rob_id == id)) begin
        rsp.ready = 1'b1;
        rsp.value = rob.cdb_value;
      end else if (r_ready[idx]) begin
        rsp.ready = 1'b1;
        rsp.value = r_value[idx];
      end
    end
    return rsp;
  endfunction

  always_comb begin
    w_q1 = '0;
    w_q2 = '0;
    w_q1 = lookup(rob.query1_id);
    w_q2 = lookup(rob.query2_id);
  end

  assign rob.rob_id_to_cmd       = idx_to_id(r_tail);
  assign rob.full_to_cmd         = w_full;
  assign rob.query1_ready        = w_q1.ready;
  assign rob.query1_value        = w_q1.value;
  assign rob.query2_ready        = w_q2.ready;
  assign rob.query2_value        = w_q2.value;
  assign rob.commit_sign_to_reg  = r_commit_sign;
  assign rob.rd_to_reg           = r_rd_out;
  assign rob.V_to_reg            = r_v_out;
  assign rob.Q_to_reg            = r_q_out;
  assign rob.rollback_sign       = r_rollback;
  assign rob.rollback_pc         = r_rollback_pc;
  assign rob.store_commit_sign   = r_store_commit;
  assign rob.store_commit_rob_id = r_store_id;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reorder_buffer                                                  |
// | Directed scoreboard bench for reorder_buffer.                      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if rif ();
  reorder_buffer dut (.clk(clk), .rst_n(rst_n), .rob(rif));

  typedef struct {
    bit          is_store;
    bit          is_rb;
    logic [4:0]  rd;
    logic [31:0] v;
    logic [4:0]  q;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int n_retired = 0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit st, input bit rb, input logic [4:0] rd,
                      input logic [31:0] v, input logic [4:0] q, input logic [31:0] pc);
    exp_t e;
    e.is_store = st; e.is_rb = rb; e.rd = rd; e.v = v; e.q = q; e.pc = pc;
    sb.push_back(e);
  endtask

  // Every retire pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rif.commit_sign_to_reg || rif.store_commit_sign || rif.rollback_sign)) begin
      n_retired++;
      if (sb.size() == 0) begin
        chk("unexpected_retire",
            {29'b0, rif.commit_sign_to_reg, rif.store_commit_sign, rif.rollback_sign}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("commit_sign", rif.commit_sign_to_reg, !e.is_store);
        chk("store_commit_sign", rif.store_commit_sign, e.is_store);
        chk("rollback_sign", rif.rollback_sign, e.is_rb);
        if (e.is_store) begin
          chk("store_id", rif.store_commit_rob_id, e.q);
        end else begin
          chk("rd_to_reg", rif.rd_to_reg, e.rd);
          chk("V_to_reg", rif.V_to_reg, e.v);
          chk("Q_to_reg", rif.Q_to_reg, e.q);
          if (e.is_rb) chk("rollback_pc", rif.rollback_pc, e.pc);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input bit st, input bit br, input bit pred);
    rif.rd_from_cmd = rd;
    rif.is_store_from_cmd = st;
    rif.is_branch_from_cmd = br;
    rif.pred_taken_from_cmd = pred;
    rif.alloc_sign_from_cmd = 1'b1;
    tick();
    rif.alloc_sign_from_cmd = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] val, input bit tk,
                     input logic [31:0] tpc);
    rif.cdb_rob_id = id;
    rif.cdb_value = val;
    rif.cdb_taken = tk;
    rif.cdb_target_pc = tpc;
    rif.cdb_valid = 1'b1;
    tick();
    rif.cdb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rif.alloc_sign_from_cmd = 0; rif.rd_from_cmd = 0; rif.is_store_from_cmd = 0;
    rif.is_branch_from_cmd = 0; rif.pred_taken_from_cmd = 0; rif.cdb_valid = 0;
    rif.cdb_rob_id = 0; rif.cdb_value = 0; rif.cdb_taken = 0; rif.cdb_target_pc = 0;
    rif.query1_id = 0; rif.query2_id = 0;

    tick(3);
    chk("rst_rob_id", rif.rob_id_to_cmd, 1);
    chk("rst_full", rif.full_to_cmd, 0);
    chk("rst_commit", rif.commit_sign_to_reg, 0);
    chk("rst_rollback", rif.rollback_sign, 0);
    chk("rst_store", rif.store_commit_sign, 0);
    rst_n = 1'b1;
    tick();

    // Simple alloc + writeback + commit with query bypass
    alloc(5'd3, 0, 0, 0);
    push(0, 0, 5'd3, 32'hDEAD, 5'd1, 0);
    rif.query1_id = 5'd1;
    rif.cdb_rob_id = 5'd1; rif.cdb_value = 32'hDEAD; rif.cdb_taken = 0; rif.cdb_valid = 1;
    #1;
    chk("q1_bypass_ready", rif.query1_ready, 1);
    chk("q1_bypass_value", rif.query1_value, 32'hDEAD);
    tick();
    rif.cdb_valid = 0;
    chk("q1_stored_ready", rif.query1_ready, 1);
    chk("q1_stored_value", rif.query1_value, 32'hDEAD);
    chk("no_early_commit", rif.commit_sign_to_reg, 0);
    tick();
    chk("commit_visible", rif.commit_sign_to_reg, 1);
    chk("q1_after_retire", rif.query1_ready, 0);
    tick(2);
    chk("retired_count_t2", n_retired, 1);

    // Asynchronous reset with live entries
    for (int i = 1; i <= 5; i++) alloc(5'(i), 0, 0, 0);
    chk("rob_id_after5", rif.rob_id_to_cmd, 7);
    rif.query1_id = 5'd2;
    chk("q_busy_not_ready", rif.query1_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rob_id", rif.rob_id_to_cmd, 1);
    chk("async_full", rif.full_to_cmd, 0);
    chk("async_rd", rif.rd_to_reg, 0);
    chk("async_V", rif.V_to_reg, 0);
    chk("async_Q", rif.Q_to_reg, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill, drop while full, wrap, full-with-retire refusal
    for (int i = 1; i <= 16; i++) alloc(5'(i), 0, 0, 0);
    chk("full_16", rif.full_to_cmd, 1);
    chk("wrap_id_full", rif.rob_id_to_cmd, 1);
    alloc(5'd31, 0, 0, 0);
    chk("full_after_drop", rif.full_to_cmd, 1);
    push(0, 0, 5'd1, 32'h100, 5'd1, 0);
    cdb(5'd1, 32'h100, 0, 0);
    chk("full_before_retire", rif.full_to_cmd, 1);
    tick();
    chk("full_after_retire", rif.full_to_cmd, 0);
    chk("next_id_wrapped", rif.rob_id_to_cmd, 1);
    alloc(5'd20, 0, 0, 0);
    chk("full_again", rif.full_to_cmd, 1);
    chk("rob_id_after_wrap", rif.rob_id_to_cmd, 2);
    push(0, 0, 5'd2, 32'h200, 5'd2, 0);
    cdb(5'd2, 32'h200, 0, 0);
    rif.rd_from_cmd = 5'd21;
    rif.alloc_sign_from_cmd = 1'b1;
    tick();
    rif.alloc_sign_from_cmd = 1'b0;
    chk("full_retire_refuse_full", rif.full_to_cmd, 0);
    chk("full_retire_refuse_id", rif.rob_id_to_cmd, 2);
    tick(2);
    chk("sb_drained_t3", sb.size(), 0);
    do_reset();

    // Out-of-order writeback, in-order retire
    alloc(5'd7, 0, 0, 0);
    alloc(5'd8, 0, 0, 0);
    push(0, 0, 5'd7, 32'hA1, 5'd1, 0);
    push(0, 0, 5'd8, 32'hB2, 5'd2, 0);
    base = n_retired;
    cdb(5'd2, 32'hB2, 0, 0);
    tick(3);
    chk("ooo_no_commit", n_retired - base, 0);
    rif.query2_id = 5'd2;
    #1;
    chk("q2_ready", rif.query2_ready, 1);
    chk("q2_value", rif.query2_value, 32'hB2);
    cdb(5'd1, 32'hA1, 0, 0);
    chk("ooo_wait", rif.commit_sign_to_reg, 0);
    tick();
    chk("ooo_first", rif.commit_sign_to_reg, 1);
    chk("ooo_first_Q", rif.Q_to_reg, 1);
    tick();
    chk("ooo_second", rif.commit_sign_to_reg, 1);
    chk("ooo_second_Q", rif.Q_to_reg, 2);
    tick();
    chk("ooo_pulse_end", rif.commit_sign_to_reg, 0);

    // Mispredicted branch flushes younger entries
    alloc(5'd9, 0, 1, 0);
    alloc(5'd10, 0, 0, 0);
    alloc(5'd11, 0, 0, 0);
    cdb(5'd4, 32'h44, 0, 0);
    cdb(5'd5, 32'h55, 0, 0);
    push(0, 1, 5'd9, 32'h1044, 5'd3, 32'h1040);
    cdb(5'd3, 32'h1044, 1, 32'h1040);
    tick();
    chk("rb_sign", rif.rollback_sign, 1);
    chk("rb_pc", rif.rollback_pc, 32'h1040);
    chk("rb_rob_id", rif.rob_id_to_cmd, 1);
    chk("rb_full", rif.full_to_cmd, 0);
    rif.rd_from_cmd = 5'd12;
    rif.alloc_sign_from_cmd = 1'b1;
    tick();
    rif.alloc_sign_from_cmd = 1'b0;
    chk("rb_alloc_ignored", rif.rob_id_to_cmd, 1);
    chk("rb_pulse_end", rif.rollback_sign, 0);
    alloc(5'd13, 0, 0, 0);
    push(0, 0, 5'd13, 32'h77, 5'd1, 0);
    cdb(5'd1, 32'h77, 0, 0);
    tick(3);

    // Store retire and a correctly predicted branch
    alloc(5'd0, 1, 0, 0);
    push(1, 0, 5'd0, 0, 5'd2, 0);
    cdb(5'd2, 32'h1, 0, 0);
    tick();
    chk("store_pulse", rif.store_commit_sign, 1);
    chk("store_no_reg", rif.commit_sign_to_reg, 0);
    alloc(5'd14, 0, 1, 1);
    push(0, 0, 5'd14, 32'h3000, 5'd3, 0);
    cdb(5'd3, 32'h3000, 1, 32'h5000);
    tick(3);
    rif.query1_id = 5'd0;
    #1;
    chk("q_id0_ready", rif.query1_ready, 0);
    chk("q_id0_value", rif.query1_value, 0);
    chk("sb_drained_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
